div_ctrl: RTL
=============

# div_ctrl

Sequencing controller for the two divider IP cores (signed and unsigned) used by the EXE stage. It latches one divide request per instruction, drives the AXI-stream operand handshake to the selected core exactly once, and waits for the result pulse. It then holds the selected quotient or remainder until the EXE stage consumes it. It replaces ad-hoc tvalid/"issued" flags inside EXE, and EXE uses `done_valid` as its ready-go for div/mod ops.

## Interface
- DATA_W, 32, operand width; each core output is 2*DATA_W wide.
- clk  in  1  clock; one clock domain.
- reset  in  1  reset; synchronous, active-high.
- req_valid  in  1  EXE holds a valid div/mod op; held high while EXE stalls.
- req_signed  in  1  1: signed core, 0: unsigned core.
- req_rem  in  1  1: return remainder, 0: return quotient.
- req_dividend  in  DATA_W  dividend (rj).
- req_divisor  in  DATA_W  divisor (rk).
- cancel  in  1  abandon the current op (pipeline flush); see Configuration.
- done_valid  out  1  result valid; EXE ready-go.
- done_result  out  DATA_W  selected quotient or remainder.
- done_ack  in  1  EXE accepts the result (es_ready_go & ms_allowin).
- busy  out  1  state != IDLE.
- div_dividend_tdata  out  DATA_W  latched dividend, shared by both cores.
- div_divisor_tdata  out  DATA_W  latched divisor, shared by both cores.
- s_dividend_tvalid, s_divisor_tvalid  out  1 each  signed core operand valids.
- s_dividend_tready, s_divisor_tready  in  1 each  signed core operand readys.
- s_dout_tvalid  in  1  signed result pulse (single cycle, no tready).
- s_dout_tdata  in  2*DATA_W  signed result: [63:32] quotient, [31:0] remainder.
- u_dividend_tvalid, u_divisor_tvalid, u_dividend_tready, u_divisor_tready, u_dout_tvalid, u_dout_tdata: unsigned core, same meanings.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE, plus DRAIN when DIV_CANCEL_EN is defined.
- IDLE, req_valid=1: latch operands, req_signed and req_rem; go to ISSUE.
- ISSUE: assert both tvalids of the selected core only; the other core's tvalids stay 0.
  - Each channel is tracked independently. A channel's tvalid drops the cycle after its own tvalid&tready.
  - The state moves to WAIT once both channels are accepted, whether in the same cycle or different cycles.
  - tvalid never drops before acceptance, and tdata stays stable while tvalid is high.
- WAIT, selected dout_tvalid=1: capture [63:32] when req_rem=0, otherwise [31:0], into done_result; go to DONE.
- DONE: done_valid=1. On done_ack go to IDLE, so a new request can be accepted no earlier than the following cycle.
- dout_tvalid from the non-selected core, or in IDLE, ISSUE or DONE, is ignored.
- Divisor 0: no special case; done_result is whatever the core returns.
- Request inputs are ignored outside IDLE.

## Timing
- Reset values: all tvalids 0, done_valid 0, done_result 0, both tdata outputs 0, busy 0, state IDLE.
- Reset mid-operation returns to IDLE at once. The cores share the system reset.
- The earliest tvalid appears 1 cycle after req_valid is sampled in IDLE.
- done_valid rises 1 cycle after the dout_tvalid pulse.
- Total latency = 1 + handshake cycles + core latency + 1.
- done_result is registered and stable for the whole DONE state.

## Configuration
- DIV_CANCEL_EN defined:
  - cancel in IDLE or DONE: go to IDLE next cycle; done_valid drops.
  - cancel in ISSUE or WAIT: go to DRAIN.
  - DRAIN: keep any unaccepted tvalid until accepted, wait for the selected dout_tvalid, discard it, go to IDLE. done_valid stays 0 and busy stays 1 throughout.
  - cancel has priority over done_ack and dout_tvalid in the same cycle.
- DIV_CANCEL_EN undefined: the cancel port exists but is ignored. The DRAIN state and its logic are absent.

## Structure
- Package div_ctrl_pkg holds:
  - the FSM state encoding;
  - the result field bounds QUO_HI/QUO_LO/REM_HI/REM_LO, derived from DATA_W.
- One sub-module, div_issue_hs: the per-core two-channel tvalid tracker.
  - Inputs: start, tready pair. Outputs: tvalid pair, all_accepted.
  - Instantiated twice, once per core.

## Test plan
- Signed 100 / -7, req_rem=0, both treadys high → one cycle of both s_ tvalids, u_ tvalids 0; done_result=0xFFFFFFF2 (-14); done_valid held until done_ack.
- Unsigned 0xFFFFFFFF / 16, req_rem=1, dividend tready delayed 3 cycles → divisor tvalid drops after its accept, dividend tvalid held 3 cycles; done_result=0x0000000F.
- done_ack held low 5 cycles in DONE → done_result stable and no new issue; ack then back-to-back req → next tvalid exactly 2 cycles after ack.
- reset asserted in WAIT → next cycle all outputs at reset values; a later stray s_dout_tvalid in IDLE produces no done_valid.
- DIV_CANCEL_EN: cancel in WAIT with 7 / 2 → DRAIN, result pulse discarded, done_valid never 1, IDLE the cycle after the pulse; next op 9 / 3 returns quotient 3.
- Signed divide 5 / 0 → completes normally; done_valid asserts after core latency, no hang.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared types and result field bounds for div_ctrl (DRAIN state under DIV_CANCEL_EN)
package div_ctrl_pkg;

   localparam int DATA_W = 32;

   // Core output layout: quotient in the upper half, remainder in the lower half
   localparam int QUO_HI = 2*DATA_W - 1;
   localparam int QUO_LO = DATA_W;
   localparam int REM_HI = DATA_W - 1;
   localparam int REM_LO = 0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DONE  = 3'd3
`ifdef DIV_CANCEL_EN
      ,
      ST_DRAIN = 3'd4
`endif
   } div_state_t;

endpackage

// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - EXE request/result and divider core stream signals for div_ctrl
interface div_ctrl_if;
   import div_ctrl_pkg::*;

   logic                req_valid;
   logic                req_signed;
   logic                req_rem;
   logic [DATA_W-1:0]   req_dividend;
   logic [DATA_W-1:0]   req_divisor;
   logic                cancel;
   logic                done_valid;
   logic [DATA_W-1:0]   done_result;
   logic                done_ack;
   logic                busy;

   logic [DATA_W-1:0]   div_dividend_tdata;
   logic [DATA_W-1:0]   div_divisor_tdata;

   logic                s_dividend_tvalid;
   logic                s_divisor_tvalid;
   logic                s_dividend_tready;
   logic                s_divisor_tready;
   logic                s_dout_tvalid;
   logic [2*DATA_W-1:0] s_dout_tdata;

   logic                u_dividend_tvalid;
   logic                u_divisor_tvalid;
   logic                u_dividend_tready;
   logic                u_divisor_tready;
   logic                u_dout_tvalid;
   logic [2*DATA_W-1:0] u_dout_tdata;

   // Controller side
   modport slave (
      input  req_valid, req_signed, req_rem, req_dividend, req_divisor, cancel, done_ack,
      output done_valid, done_result, busy, div_dividend_tdata, div_divisor_tdata,
      output s_dividend_tvalid, s_divisor_tvalid,
      input  s_dividend_tready, s_divisor_tready, s_dout_tvalid, s_dout_tdata,
      output u_dividend_tvalid, u_divisor_tvalid,
      input  u_dividend_tready, u_divisor_tready, u_dout_tvalid, u_dout_tdata
   );

   // EXE stage plus the two divider cores
   modport master (
      output req_valid, req_signed, req_rem, req_dividend, req_divisor, cancel, done_ack,
      input  done_valid, done_result, busy, div_dividend_tdata, div_divisor_tdata,
      input  s_dividend_tvalid, s_divisor_tvalid,
      output s_dividend_tready, s_divisor_tready, s_dout_tvalid, s_dout_tdata,
      input  u_dividend_tvalid, u_divisor_tvalid,
      output u_dividend_tready, u_divisor_tready, u_dout_tvalid, u_dout_tdata
   );

endinterface

// File: rtl/div_issue_hs.sv
// rtl/div_issue_hs.sv - per-core dividend/divisor tvalid tracker, each channel retired independently
module div_issue_hs (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic dividend_tready,
   input  logic divisor_tready,
   output logic dividend_tvalid,
   output logic divisor_tvalid,
   output logic all_accepted
);

   // High in the cycle the last outstanding channel is taken (or both together)
   assign all_accepted = (dividend_tvalid | divisor_tvalid)
                       & (~dividend_tvalid | dividend_tready)
                       & (~divisor_tvalid  | divisor_tready);

   // Raise both valids on start; each drops only after its own handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         dividend_tvalid <= 1'b0;
         divisor_tvalid  <= 1'b0;
      end else if (start) begin
         dividend_tvalid <= 1'b1;
         divisor_tvalid  <= 1'b1;
      end else begin
         if (dividend_tvalid && dividend_tready) dividend_tvalid <= 1'b0;
         if (divisor_tvalid && divisor_tready)   divisor_tvalid  <= 1'b0;
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - divide request sequencer for the signed/unsigned divider cores; cancel/DRAIN under DIV_CANCEL_EN
module div_ctrl (
   input  logic        clk,
   input  logic        reset,
   div_ctrl_if.slave   bus
);
   import div_ctrl_pkg::*;

   div_state_t          state;
   logic                sel_signed;
   logic                sel_rem;
   logic                start;
   logic                s_all_accepted;
   logic                u_all_accepted;
   logic                hs_done;
   logic                dout_hit;
   logic [2*DATA_W-1:0] dout_data;

`ifdef DIV_CANCEL_EN
   // A flush in IDLE also blocks a request presented in the same cycle
   assign start = (state == ST_IDLE) && bus.req_valid && !bus.cancel;
`else
   assign start = (state == ST_IDLE) && bus.req_valid;
`endif

   // Only the core chosen at issue time may advance the FSM
   assign hs_done   = sel_signed ? s_all_accepted : u_all_accepted;
   assign dout_hit  = sel_signed ? bus.s_dout_tvalid : bus.u_dout_tvalid;
   assign dout_data = sel_signed ? bus.s_dout_tdata  : bus.u_dout_tdata;

   div_issue_hs u_hs_signed (
      .clk             (clk),
      .reset           (reset),
      .start           (start && bus.req_signed),
      .dividend_tready (bus.s_dividend_tready),
      .divisor_tready  (bus.s_divisor_tready),
      .dividend_tvalid (bus.s_dividend_tvalid),
      .divisor_tvalid  (bus.s_divisor_tvalid),
      .all_accepted    (s_all_accepted)
   );

   div_issue_hs u_hs_unsigned (
      .clk             (clk),
      .reset           (reset),
      .start           (start && !bus.req_signed),
      .dividend_tready (bus.u_dividend_tready),
      .divisor_tready  (bus.u_divisor_tready),
      .dividend_tvalid (bus.u_dividend_tvalid),
      .divisor_tvalid  (bus.u_divisor_tvalid),
      .all_accepted    (u_all_accepted)
   );

   // Main sequencing FSM with registered result, done and busy outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state                  <= ST_IDLE;
         sel_signed             <= 1'b0;
         sel_rem                <= 1'b0;
         bus.div_dividend_tdata <= '0;
         bus.div_divisor_tdata  <= '0;
         bus.done_valid         <= 1'b0;
         bus.done_result        <= '0;
         bus.busy               <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sel_signed             <= bus.req_signed;
                  sel_rem                <= bus.req_rem;
                  bus.div_dividend_tdata <= bus.req_dividend;
                  bus.div_divisor_tdata  <= bus.req_divisor;
                  bus.busy               <= 1'b1;
                  state                  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
`ifdef DIV_CANCEL_EN
               if (bus.cancel) state <= ST_DRAIN;
               else
`endif
               if (hs_done) state <= ST_WAIT;
            end
            ST_WAIT: begin
`ifdef DIV_CANCEL_EN
               if (bus.cancel) state <= ST_DRAIN;
               else
`endif
               if (dout_hit) begin
                  bus.done_result <= sel_rem ? dout_data[REM_HI:REM_LO]
                                             : dout_data[QUO_HI:QUO_LO];
                  bus.done_valid  <= 1'b1;
                  state           <= ST_DONE;
               end
            end
            ST_DONE: begin
`ifdef DIV_CANCEL_EN
               if (bus.done_ack || bus.cancel) begin
`else
               if (bus.done_ack) begin
`endif
                  bus.done_valid <= 1'b0;
                  bus.busy       <= 1'b0;
                  state          <= ST_IDLE;
               end
            end
`ifdef DIV_CANCEL_EN
            // Operand channels keep draining in the tracker; swallow the result
            ST_DRAIN: begin
               if (dout_hit) begin
                  bus.busy <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
`endif
            default: begin
               bus.done_valid <= 1'b0;
               bus.busy       <= 1'b0;
               state          <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
